// File: rtl/cycle_writer.sv
// Write side of the circular frame-RAM window: accepts a valid/ready symbol stream,
// tracks occupancy against the reader's consume strobe and releases the reader once primed.
module cycle_writer #(
  parameter int ADDRWIDTH = 11,
  parameter int DATAWIDTH = 8,
  parameter int LDATA     = 18*55+1,
  parameter int HDATA     = 18*66,
  parameter int PRIME     = 18
) (
  input  logic                 iClk,
  input  logic                 iClrn,
  input  logic                 iValid,
  input  logic [DATAWIDTH-1:0] iData,
  output logic                 oReady,
  input  logic                 iRdEn,
  output logic                 oWrEn,
  output logic [ADDRWIDTH-1:0] oWrAddr,
  output logic [DATAWIDTH-1:0] oWrData,
  output logic                 oRdGo,
  output logic [ADDRWIDTH-1:0] oLevel,
  output logic                 oFull,
  output logic                 oUnderflow,
  output logic [1:0]           oDbgState
);

  localparam logic [ADDRWIDTH-1:0] LO      = ADDRWIDTH'(LDATA);
  localparam logic [ADDRWIDTH-1:0] HI      = ADDRWIDTH'(HDATA);
  localparam logic [ADDRWIDTH-1:0] DEPTH   = ADDRWIDTH'(HDATA - LDATA + 1);
  localparam logic [ADDRWIDTH-1:0] PRIME_L = ADDRWIDTH'(PRIME);

  typedef enum logic [1:0] {S_INIT = 2'd0, S_FILL = 2'd1, S_RUN = 2'd2} state_t;

  // Handshake: a symbol moves when iValid and oReady are both high at a rising edge;
  // oReady is registered and already accounts for the level after that edge.

  state_t                 state_q, state_d;
  logic                   init_q, init_d;
  logic [ADDRWIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDRWIDTH-1:0]   level_q, level_d;
  logic                   ready_q, ready_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDRWIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATAWIDTH-1:0]   wr_data_q, wr_data_d;
  logic                   rd_go_q, rd_go_d;
  logic                   full_q, full_d;
  logic                   under_q, under_d;

  logic                   xfer;
  logic                   rd_ok;
  logic                   ptr_ok;
  logic [ADDRWIDTH-1:0]   ptr_eff;

  always_comb begin
    xfer    = iValid & ready_q;
    rd_ok   = iRdEn & (level_q != '0);
    ptr_ok  = (ptr_q >= LO) && (ptr_q <= HI);
    ptr_eff = ptr_ok ? ptr_q : LO;

    level_d = level_q;
    if (xfer && !rd_ok)      level_d = level_q + ADDRWIDTH'(1);
    else if (!xfer && rd_ok) level_d = level_q - ADDRWIDTH'(1);

    // A stray pointer snaps back to the window base before it is ever used.
    ptr_d     = ptr_eff;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (xfer) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr_eff;
      wr_data_d = iData;
      ptr_d     = (ptr_eff == HI) ? LO : ptr_eff + ADDRWIDTH'(1);
    end

    state_d = state_q;
    init_d  = init_q;
    case (state_q)
      S_INIT: begin
        if (init_q) state_d = S_FILL;
        else        init_d  = 1'b1;
      end
      S_FILL:  if (level_d >= PRIME_L) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase

    ready_d = (state_q == S_INIT) ? init_q : (level_d < DEPTH);
    full_d  = (level_d == DEPTH);
    rd_go_d = (state_d == S_RUN) && (level_d != '0);
    under_d = under_q | (iRdEn & (level_q == '0));
  end

  always_ff @(posedge iClk or negedge iClrn) begin
    if (!iClrn) begin
      state_q   <= S_INIT;
      init_q    <= 1'b0;
      ptr_q     <= LO;
      level_q   <= '0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= LO;
      wr_data_q <= '0;
      rd_go_q   <= 1'b0;
      full_q    <= 1'b0;
      under_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_q    <= init_d;
      ptr_q     <= ptr_d;
      level_q   <= level_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_go_q   <= rd_go_d;
      full_q    <= full_d;
      under_q   <= under_d;
    end
  end

  assign oReady     = ready_q;
  assign oWrEn      = wr_en_q;
  assign oWrAddr    = wr_addr_q;
  assign oWrData    = wr_data_q;
  assign oRdGo      = rd_go_q;
  assign oLevel     = level_q;
  assign oFull      = full_q;
  assign oUnderflow = under_q;
  assign oDbgState  = state_q;

endmodule

// File: tb/tb_cycle_writer.sv
// Directed bench for cycle_writer: default 198-deep window plus a 4-deep override instance.
module tb_cycle_writer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        valid, rd_en;
  logic [7:0]  data;
  logic        ready, wr_en, rd_go, full, under;
  logic [10:0] wr_addr, level;
  logic [7:0]  wr_data;
  logic [1:0]  dbg;

  logic        s_valid, s_rd_en;
  logic [7:0]  s_data;
  logic        s_ready, s_wr_en, s_rd_go, s_full, s_under;
  logic [10:0] s_wr_addr, s_level;
  logic [7:0]  s_wr_data;
  logic [1:0]  s_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [33:0] got, want;

  cycle_writer u_dut (
    .iClk(clk), .iClrn(rst_n), .iValid(valid), .iData(data), .oReady(ready),
    .iRdEn(rd_en), .oWrEn(wr_en), .oWrAddr(wr_addr), .oWrData(wr_data),
    .oRdGo(rd_go), .oLevel(level), .oFull(full), .oUnderflow(under), .oDbgState(dbg)
  );

  cycle_writer #(.ADDRWIDTH(11), .DATAWIDTH(8), .LDATA(4), .HDATA(7), .PRIME(4)) u_small (
    .iClk(clk), .iClrn(rst_n), .iValid(s_valid), .iData(s_data), .oReady(s_ready),
    .iRdEn(s_rd_en), .oWrEn(s_wr_en), .oWrAddr(s_wr_addr), .oWrData(s_wr_data),
    .oRdGo(s_rd_go), .oLevel(s_level), .oFull(s_full), .oUnderflow(s_under), .oDbgState(s_dbg)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; valid = 1'b0; data = 8'd0; rd_en = 1'b0;
    s_valid = 1'b0; s_data = 8'd0; s_rd_en = 1'b0;
    #12;
    got  = {wr_en, wr_addr, wr_data, level, full, ready, rd_go};
    want = {1'b0, 11'd991, 8'd0, 11'd0, 1'b0, 1'b0, 1'b0};
    n_vec++;
    if (got !== want || under !== 1'b0 || dbg !== 2'd0) begin
      n_err++;
      $display("FAIL reset_values: got %h/%b/%0d expected %h/0/0", got, under, dbg, want);
    end
    n_vec++;
    if (s_wr_addr !== 11'd4 || s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL small_reset: got addr %0d ready %b expected addr 4 ready 0", s_wr_addr, s_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_edge1: got %b expected 0", ready);
    end
    tick();
    n_vec++;
    if (ready !== 1'b1 || level !== 11'd0 || rd_go !== 1'b0 || dbg !== 2'd1) begin
      n_err++;
      $display("FAIL ready_edge2: got ready %b level %0d go %b st %0d expected 1 0 0 1",
               ready, level, rd_go, dbg);
    end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 198; i++) begin
      valid = 1'b1;
      data  = 8'(i);
      tick();
      got  = {wr_en, wr_addr, wr_data, level, full, ready, rd_go};
      want = {1'b1, 11'(991 + i), 8'(i), 11'(i + 1), (i == 197), (i != 197), ((i + 1) >= 18)};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL fill[%0d]: got %h expected %h", i, got, want);
      end
    end
    valid = 1'b0;
    tick();
    got  = {wr_en, wr_addr, wr_data, level, full, ready, rd_go};
    want = {1'b0, 11'd1188, 8'd197, 11'd198, 1'b1, 1'b0, 1'b1};
    n_vec++;
    if (got !== want || dbg !== 2'd2) begin
      n_err++;
      $display("FAIL fill_hold: got %h st %0d expected %h st 2", got, dbg, want);
    end
  endtask

  task automatic test_wrap_at_full;
    valid = 1'b1; data = 8'hAA; rd_en = 1'b1;
    tick();
    got  = {wr_en, wr_addr, wr_data, level, full, ready, rd_go};
    want = {1'b0, 11'd1188, 8'd197, 11'd197, 1'b0, 1'b1, 1'b1};
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL full_read: got %h expected %h", got, want);
    end
    rd_en = 1'b0;
    tick();
    got  = {wr_en, wr_addr, wr_data, level, full, ready, rd_go};
    want = {1'b1, 11'd991, 8'hAA, 11'd198, 1'b1, 1'b0, 1'b1};
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL wrap_write: got %h expected %h", got, want);
    end
    valid = 1'b0; rd_en = 1'b1;
    tick();
    valid = 1'b1; data = 8'hBB;
    tick();
    got  = {wr_en, wr_addr, wr_data, level, full, ready, rd_go};
    want = {1'b1, 11'd992, 8'hBB, 11'd197, 1'b0, 1'b1, 1'b1};
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL rw_at_depth_m1: got %h expected %h", got, want);
    end
    valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    rst_n = 1'b0;
    #1;
    release_reset();
    for (int i = 0; i < 50; i++) begin
      valid = 1'b1;
      data  = 8'(i + 3);
      tick();
      n_vec++;
      if (wr_addr !== 11'(991 + i) || level !== 11'(i + 1) || rd_go !== ((i + 1) >= 18)) begin
        n_err++;
        $display("FAIL pre_reset[%0d]: got addr %0d level %0d go %b expected %0d %0d %b",
                 i, wr_addr, level, rd_go, 991 + i, i + 1, ((i + 1) >= 18));
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    got  = {wr_en, wr_addr, wr_data, level, full, ready, rd_go};
    want = {1'b0, 11'd991, 8'd0, 11'd0, 1'b0, 1'b0, 1'b0};
    n_vec++;
    if (got !== want || under !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got %h/%b expected %h/0", got, under, want);
    end
    valid = 1'b0;
    release_reset();
    for (int i = 0; i < 18; i++) begin
      valid = 1'b1;
      data  = 8'(i);
      tick();
      got  = {wr_en, wr_addr, wr_data, level, full, ready, rd_go};
      want = {1'b1, 11'(991 + i), 8'(i), 11'(i + 1), 1'b0, 1'b1, (i == 17)};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL refill[%0d]: got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back;
    valid = 1'b1; rd_en = 1'b1;
    for (int k = 0; k < 220; k++) begin
      data = 8'(k);
      tick();
      got  = {wr_en, wr_addr, wr_data, level, full, ready, rd_go};
      want = {1'b1, 11'(991 + ((18 + k) % 198)), 8'(k), 11'd18, 1'b0, 1'b1, 1'b1};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL steady[%0d]: got %h expected %h", k, got, want);
      end
    end
    valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_underflow;
    rd_en = 1'b1;
    for (int j = 1; j <= 18; j++) begin
      tick();
      n_vec++;
      if (level !== 11'(18 - j) || rd_go !== (j != 18) || under !== 1'b0) begin
        n_err++;
        $display("FAIL drain[%0d]: got level %0d go %b uf %b expected %0d %b 0",
                 j, level, rd_go, under, 18 - j, (j != 18));
      end
    end
    tick();
    n_vec++;
    if (level !== 11'd0 || under !== 1'b1 || rd_go !== 1'b0) begin
      n_err++;
      $display("FAIL underflow_set: got level %0d uf %b go %b expected 0 1 0", level, under, rd_go);
    end
    valid = 1'b1; data = 8'h5A;
    tick();
    got  = {wr_en, wr_addr, wr_data, level, full, ready, rd_go};
    want = {1'b1, 11'd1031, 8'h5A, 11'd1, 1'b0, 1'b1, 1'b1};
    n_vec++;
    if (got !== want || under !== 1'b1) begin
      n_err++;
      $display("FAIL empty_rw: got %h/%b expected %h/1", got, under, want);
    end
    valid = 1'b0; rd_en = 1'b0;
    tick();
    n_vec++;
    if (wr_en !== 1'b0 || level !== 11'd1 || under !== 1'b1 || dbg !== 2'd2) begin
      n_err++;
      $display("FAIL underflow_sticky: got we %b level %0d uf %b st %0d expected 0 1 1 2",
               wr_en, level, under, dbg);
    end
  endtask

  task automatic test_small_window;
    rst_n = 1'b0;
    #1;
    release_reset();
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(16 + i);
      tick();
      got = {s_wr_en, s_wr_addr, s_wr_data, s_level, s_full, s_ready, s_rd_go};
      if (i < 4)
        want = {1'b1, 11'(4 + i), 8'(16 + i), 11'(i + 1), (i == 3), (i != 3), (i == 3)};
      else
        want = {1'b0, 11'd7, 8'd19, 11'd4, 1'b1, 1'b0, 1'b1};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL small[%0d]: got %h expected %h", i, got, want);
      end
    end
    s_rd_en = 1'b1;
    tick();
    s_rd_en = 1'b0;
    tick();
    got  = {s_wr_en, s_wr_addr, s_wr_data, s_level, s_full, s_ready, s_rd_go};
    want = {1'b1, 11'd4, 8'd20, 11'd4, 1'b1, 1'b0, 1'b1};
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL small_wrap: got %h expected %h", got, want);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wrap_at_full();
    test_reset_mid();
    test_back_to_back();
    test_underflow();
    test_small_window();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cycle_writer.md
# cycle_writer

Write-side companion of the cycle read-address counter. Accepts a valid/ready symbol stream and writes it into the circular RAM window [LDATA, HDATA]. Tracks occupancy against the reader's consume strobe and gates reader start until a prime threshold is buffered. Sits between the upstream symbol source and the dual-port frame RAM; the reader counter runs on the same window and the same clock.

## Interface
- ADDRWIDTH, 11, RAM address width; also the width of the occupancy level
- DATAWIDTH, 8, symbol width
- LDATA, 18*55+1 (991), lowest window address
- HDATA, 18*66 (1188), highest window address; DEPTH = HDATA-LDATA+1 (198)
- PRIME, 18, occupancy that must be reached before the reader is released; 1 ≤ PRIME ≤ DEPTH

Ports:
- iClk  in  1  clock; single clock domain
- iClrn  in  1  reset; asynchronous, active-low
- iValid  in  1  upstream symbol valid
- iData  in  DATAWIDTH  upstream symbol
- oReady  out  1  writer can accept; transfer = iValid & oReady
- iRdEn  in  1  reader consumed one symbol this cycle (same strobe as reader counter enable)
- oWrEn  out  1  RAM write strobe
- oWrAddr  out  ADDRWIDTH  RAM write address
- oWrData  out  DATAWIDTH  RAM write data
- oRdGo  out  1  reader enable permitted (RUN state and level ≠ 0)
- oLevel  out  ADDRWIDTH  current occupancy, 0..DEPTH
- oFull  out  1  level == DEPTH
- oUnderflow  out  1  sticky: iRdEn seen while level == 0

## Operation
- All outputs registered. Reset values: oReady 0, oWrEn 0, oWrAddr LDATA, oWrData 0, oRdGo 0, oLevel 0, oFull 0, oUnderflow 0; state INIT.
- States:
  - INIT: one cycle after reset release. oReady goes 1 on exit. Transitions to FILL.
  - FILL: accept writes; oRdGo 0. Go to RUN on the edge where the level becomes ≥ PRIME.
  - RUN: oRdGo = (level_next ≠ 0). Stays in RUN until reset; level dropping to 0 does not return to FILL.
- Write: on transfer at edge N, the outputs at N+1 are oWrEn=1, oWrData=iData and oWrAddr = the write pointer. The pointer then advances.
- Pointer wrap: HDATA → LDATA. If the pointer is ever outside [LDATA, HDATA], force it to LDATA with no write at that address.
- oWrEn is 0 in every cycle without a transfer; oWrAddr and oWrData hold their values.
- Level update each edge: +1 on transfer only, −1 on valid read only, unchanged on both or neither.
- Valid read = iRdEn & level ≠ 0.
- iRdEn with level 0: level stays 0 and oUnderflow sets. oUnderflow clears only on reset.
- oReady = (level_next < DEPTH), registered, so it never permits a write into a full window.
- oFull = (level_next == DEPTH).
- iRdEn in INIT/FILL counts as a read if level ≠ 0. Upstream misuse is flagged only by oUnderflow.
- Arithmetic: level and pointer are unsigned ADDRWIDTH bits. DEPTH must fit, i.e. HDATA < 2^ADDRWIDTH.

## Timing
- Input transfer → RAM write strobe: 1 cycle.
- Transfer → oLevel, oFull, oReady reflect it: 1 cycle.
- Full boundary: level DEPTH−1 plus a transfer gives oFull=1 and oReady=0 next cycle. A simultaneous read and write at DEPTH−1 keeps the level at DEPTH−1 with oReady=1.
- At full, iRdEn alone gives level DEPTH−1 and oReady=1 the next cycle.
- Empty boundary: level 1 plus iRdEn alone gives level 0 and oRdGo=0 next cycle. Level 0 with a simultaneous transfer and iRdEn gives level 1 (read ignored) and sets oUnderflow.
- Reset mid-operation: all outputs return to reset values immediately (async). The pointer restarts at LDATA after INIT, and buffered data is discarded.
- Reset release: oReady is first 1 at the second rising edge after iClrn rises.

## Test plan
- Reset, then stream 198 symbols 0..197 with iRdEn=0 → writes at addresses 991..1188, in order. oRdGo rises when oLevel reaches 18. oFull=1 and oReady=0 after the 198th symbol.
- At full, pulse iRdEn once with iValid held → the level goes 198→197, oReady returns, and the next write lands at 991 (wrap).
- Continuous stream with iRdEn=1 every cycle after oRdGo → level holds at 18, and addresses wrap 1188→991 repeatedly with no gaps.
- iRdEn=1 at level 0 in RUN → oUnderflow=1 (sticky), level stays 0, and the following transfer produces level 1.
- Assert iClrn low mid-stream at level 50 → all outputs reset the same cycle. After release, the first write is at 991, and oRdGo stays low until the level is 18.
- Parameter override LDATA=4, HDATA=7, PRIME=4 → depth 4, addresses cycle 4,5,6,7,4, and full is reached after 4 writes.
